// File: rtl/tt_sub_pkg.sv
// Shared definitions for the bit-serial subtractor tile: FSM encoding, uio bit map,
// and a helper for sizing the bit counter.
package tt_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // uio_in strobe positions
  localparam int LOAD_A = 0;
  localparam int LOAD_B = 1;
  localparam int START  = 2;

  // uio_out status positions
  localparam int DONE   = 4;
  localparam int BORROW = 5;
  localparam int BUSY   = 6;
  localparam int ZERO   = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  // Counter needs at least one bit even when only a single bit is processed.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor (a - b - bin) built from two half subtractors and an OR
// that merges their borrows.
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  assign hs1_d = a ^ b;
  assign hs1_b = ~a & b;

  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;

  assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial A - B tile: operands loaded byte-wide, difference computed LSB first
// through one borrow-chained cell, result and flags latched on completion.
module tt_um_serial_subtractor
  import tt_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int                 CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q;
  state_t             state_d;

  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  logic [WIDTH-1:0]   sh_a_q;
  logic [WIDTH-1:0]   sh_b_q;
  logic [WIDTH-1:0]   res_sr_q;
  logic [WIDTH-1:0]   res_next;
  logic [WIDTH-1:0]   result_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               borrow_ff_q;
  logic               done_q;
  logic               borrow_q;
  logic               zero_q;

  logic               load_a;
  logic               load_b;
  logic               start;
  logic               load_any;
  logic               start_go;
  logic               running;
  logic               last_bit;
  logic               cell_d;
  logic               cell_bout;
  logic               unused_ok;

  assign load_a   = uio_in[LOAD_A];
  assign load_b   = uio_in[LOAD_B];
  assign start    = uio_in[START];
  assign load_any = load_a | load_b;
  // A load in the same cycle takes priority; start is dropped.
  assign start_go = start & ~load_any;
  assign running  = (state_q == ST_RUN);
  assign last_bit = running && (cnt_q == CNT_LAST);

  assign unused_ok = &{1'b0, uio_in[7:3], ui_in, res_sr_q[0]};

  sub_bit_cell u_cell (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .bin  (borrow_ff_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // New difference bit enters at the MSB so the word is aligned after WIDTH shifts.
  always_comb begin
    res_next            = res_sr_q >> 1;
    res_next[WIDTH-1]   = cell_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_go) state_d = ST_RUN;
      ST_RUN:           if (cnt_q == CNT_LAST) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      res_sr_q    <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      borrow_ff_q <= 1'b0;
      done_q      <= 1'b0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
    end else if (ena) begin
      if (!running) begin
        if (load_a) op_a_q <= ui_in[WIDTH-1:0];
        if (load_b) op_b_q <= ui_in[WIDTH-1:0];
        if (load_any || start) done_q <= 1'b0;
        if (start_go) begin
          sh_a_q      <= op_a_q;
          sh_b_q      <= op_b_q;
          borrow_ff_q <= 1'b0;
          cnt_q       <= '0;
        end
      end else begin
        sh_a_q      <= sh_a_q >> 1;
        sh_b_q      <= sh_b_q >> 1;
        res_sr_q    <= res_next;
        borrow_ff_q <= cell_bout;
        if (last_bit) begin
          result_q <= res_next;
          borrow_q <= cell_bout;
          zero_q   <= (res_next == '0);
          done_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    uio_out         = '0;
    uio_out[DONE]   = done_q;
    uio_out[BORROW] = borrow_q;
    uio_out[BUSY]   = running;
    uio_out[ZERO]   = zero_q;
    uo_out          = 8'(result_q);
    uio_oe          = UIO_OE_MASK;
  end

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Scoreboard bench for the bit-serial subtractor: stimulus pushes expected results,
// a monitor pops and compares them whenever done rises.
module tb_tt_um_serial_subtractor;
  import tt_sub_pkg::*;

  localparam int W = 8;
  localparam logic [7:0] C_LA = 8'(1 << LOAD_A);
  localparam logic [7:0] C_LB = 8'(1 << LOAD_B);
  localparam logic [7:0] C_ST = 8'(1 << START);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_serial_subtractor #(.WIDTH(W)) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       borrow;
    logic       zero;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;
  logic [7:0] last_res = 8'h00;
  logic       done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   d;
    d = int'(a) - int'(b);
    if (d < 0) d += 256;
    e.res    = 8'(d);
    e.borrow = (a < b);
    e.zero   = (e.res == 8'h00);
    return e;
  endfunction

  // Monitor: compare on each rising edge of done.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev <= 1'b0;
    end else begin
      if (uio_out[DONE] && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          check("result",    uo_out,          exp_q[0].res);
          check("borrow",    uio_out[BORROW], exp_q[0].borrow);
          check("zero",      uio_out[ZERO],   exp_q[0].zero);
          check("busy_done", uio_out[BUSY],   0);
          check("uio_low",   uio_out[3:0],    0);
          void'(exp_q.pop_front());
        end
      end
      done_prev <= uio_out[DONE];
    end
  end

  // Assumes the caller sits at a negedge; returns at the next negedge.
  task automatic drive(input logic [7:0] ctl, input logic [7:0] data);
    ui_in  = data;
    uio_in = ctl;
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    drive(C_LA, a);
    m_a = a;
    drive(C_LB, b);
    m_b = b;
  endtask

  task automatic wait_done(input int expect_cycles, input int start_cnt, input string name);
    int cycles;
    cycles = start_cnt;
    while (uio_out[BUSY] === 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check(name, cycles, expect_cycles);
    check({name, "_done"}, uio_out[DONE], 1);
  endtask

  task automatic start_op();
    exp_t e;
    e = model(m_a, m_b);
    exp_q.push_back(e);
    drive(C_ST, 8'h00);
    check("busy_after_start", uio_out[BUSY], 1);
    check("done_clear_on_start", uio_out[DONE], 0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    load(a, b);
    start_op();
    wait_done(W, 0, "latency");
    last_res = model(a, b).res;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_uo_out",  uo_out,  0);
    check("rst_uio_out", uio_out, 0);
    check("rst_uio_oe",  uio_oe,  8'hF0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h05, 8'h03);
    run_op(8'h03, 8'h05);
    run_op(8'h00, 8'h01);
    run_op(8'hA5, 8'hA5);
    run_op(8'hFF, 8'h00);

    // Load in DONE clears done; start with a load is ignored.
    drive(C_LA, 8'h33);
    m_a = 8'h33;
    check("load_clears_done", uio_out[DONE], 0);
    drive(C_ST | C_LB, 8'h44);
    m_b = 8'h44;
    check("start_with_load_ignored", uio_out[BUSY], 0);
    start_op();
    wait_done(W, 0, "latency_after_mixed");
    last_res = model(m_a, m_b).res;

    // Strobes during RUN are ignored.
    load(8'h10, 8'h01);
    start_op();
    repeat (2) @(negedge clk);
    check("uo_hold_in_run", uo_out, last_res);
    drive(C_ST | C_LA, 8'h77);
    wait_done(W, 3, "latency_ignore");
    last_res = model(m_a, m_b).res;
    start_op();
    wait_done(W, 0, "latency_restart");

    // Freeze with ena low mid-RUN.
    load(8'h80, 8'h7F);
    start_op();
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_frozen", uio_out[BUSY], 1);
    ena = 1'b1;
    wait_done(W + 3, 5, "latency_ena");

    // Reset mid-RUN aborts.
    load(8'h80, 8'h7F);
    start_op();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_uo_out",  uo_out,  0);
    check("abort_uio_out", uio_out, 0);
    exp_q.delete();
    m_a = 8'h00;
    m_b = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h80, 8'h7F);

    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
